// File: rtl/posit_pkg.sv
// Shared posit format constants used by the decode path.
// The leading-count field is the posit word with the sign bit stripped.
package posit_pkg;

    localparam int POSIT_NBITS = 16;
    localparam int POSIT_ES    = 1;

    localparam int LC_WIDTH = POSIT_NBITS - 1;
    localparam int LC_CNT_W = $clog2(POSIT_NBITS);

endpackage

// File: rtl/leading_count_core.sv
// Combinational leading-zero counter: distance from the MSB to the first set bit.
// An all-zero input yields WIDTH.
module leading_count_core #(
    parameter int WIDTH = 15,
    parameter int CNT_W = 4
) (
    input  logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count
);

    logic found;

    // Priority scan from the MSB; the first set bit fixes the count.
    always_comb begin
        count = CNT_W'(WIDTH);
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found && value[i]) begin
                count = CNT_W'(WIDTH - 1 - i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/leading_count15.sv
// Registered leading-zero / leading-one counter for the posit regime field.
// Both counts and the all-zero / all-one flags appear one cycle after in_valid.
module leading_count15
    import posit_pkg::*;
#(
    parameter int WIDTH = LC_WIDTH,
    parameter int CNT_W = LC_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] num,
    output logic             out_valid,
    output logic [CNT_W-1:0] leading_zeroes,
    output logic [CNT_W-1:0] leading_ones,
    output logic             all_zero,
    output logic             all_one
);

    logic [CNT_W-1:0] lz_comb;
    logic [CNT_W-1:0] lo_comb;
    logic [WIDTH-1:0] num_inv;

    assign num_inv = ~num;

    leading_count_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_lz (
        .value (num),
        .count (lz_comb)
    );

    // Leading ones of num are the leading zeroes of its complement.
    leading_count_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_lo (
        .value (num_inv),
        .count (lo_comb)
    );

    // Results load only on accepted inputs so idle-cycle garbage on num never reaches the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            leading_zeroes <= '0;
            leading_ones   <= '0;
            all_zero       <= 1'b0;
            all_one        <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                leading_zeroes <= lz_comb;
                leading_ones   <= lo_comb;
                all_zero       <= (num == '0);
                all_one        <= (&num);
            end
        end
    end

endmodule

// File: tb/tb_leading_count15.sv
// Directed and exhaustive check of leading_count15 against a log2-based reference.
module tb_leading_count15;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [14:0] num;
    logic        out_valid;
    logic [3:0]  leading_zeroes;
    logic [3:0]  leading_ones;
    logic        all_zero;
    logic        all_one;

    int vectors;
    int miscompares;

    leading_count15 dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .num            (num),
        .out_valid      (out_valid),
        .leading_zeroes (leading_zeroes),
        .leading_ones   (leading_ones),
        .all_zero       (all_zero),
        .all_one        (all_one)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [14:0] n);
        @(negedge clk);
        in_valid = v;
        num      = n;
        @(posedge clk);
        #1;
    endtask

    // lz = 14 - floor(log2 n) for n > 0, and 15 for n == 0.
    function automatic int ref_lz(input int n);
        return 15 - $clog2(n + 1);
    endfunction

    task automatic check_result(input string tag, input logic [14:0] n);
        int inv;
        inv = (~n) & 15'h7FFF;
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".lz"}, 32'(leading_zeroes), 32'(ref_lz(int'(n))));
        check({tag, ".lo"}, 32'(leading_ones), 32'(ref_lz(inv)));
        check({tag, ".az"}, 32'(all_zero), 32'(n == 15'h0000));
        check({tag, ".ao"}, 32'(all_one), 32'(n == 15'h7FFF));
    endtask

    initial begin
        logic [14:0] walk [6];
        int          walk_lz [6];

        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        num         = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset.valid", 32'(out_valid), 32'd0);
        check("reset.lz", 32'(leading_zeroes), 32'd0);
        check("reset.lo", 32'(leading_ones), 32'd0);
        check("reset.az", 32'(all_zero), 32'd0);
        check("reset.ao", 32'(all_one), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Extremes with hand-computed values.
        apply_stimulus(1'b1, 15'h0000);
        check("zero.valid", 32'(out_valid), 32'd1);
        check("zero.lz", 32'(leading_zeroes), 32'd15);
        check("zero.lo", 32'(leading_ones), 32'd0);
        check("zero.az", 32'(all_zero), 32'd1);
        check("zero.ao", 32'(all_one), 32'd0);

        apply_stimulus(1'b1, 15'h7FFF);
        check("ones.lz", 32'(leading_zeroes), 32'd0);
        check("ones.lo", 32'(leading_ones), 32'd15);
        check("ones.az", 32'(all_zero), 32'd0);
        check("ones.ao", 32'(all_one), 32'd1);

        // Walking sequence, one result per cycle.
        walk    = '{15'd1, 15'd5, 15'd33, 15'd229, 15'd1601, 15'd11205};
        walk_lz = '{14, 12, 9, 7, 4, 1};
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1'b1, walk[i]);
            check($sformatf("walk%0d.valid", i), 32'(out_valid), 32'd1);
            check($sformatf("walk%0d.lz", i), 32'(leading_zeroes), 32'(walk_lz[i]));
            check($sformatf("walk%0d.lo", i), 32'(leading_ones), 32'd0);
        end

        apply_stimulus(1'b1, 15'h6000);
        check("lo6000.lo", 32'(leading_ones), 32'd2);
        check("lo6000.lz", 32'(leading_zeroes), 32'd0);
        apply_stimulus(1'b1, 15'h4000);
        check("lo4000.lo", 32'(leading_ones), 32'd1);
        check("lo4000.lz", 32'(leading_zeroes), 32'd0);
        apply_stimulus(1'b1, 15'h7FFE);
        check("lo7ffe.lo", 32'(leading_ones), 32'd14);
        check("lo7ffe.lz", 32'(leading_zeroes), 32'd0);

        // Hold: idle cycles with an undefined num keep the last result.
        apply_stimulus(1'b1, 15'h0010);
        check("hold.lz0", 32'(leading_zeroes), 32'd10);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 'x);
            check($sformatf("hold%0d.valid", i), 32'(out_valid), 32'd0);
            check($sformatf("hold%0d.lz", i), 32'(leading_zeroes), 32'd10);
            check($sformatf("hold%0d.lo", i), 32'(leading_ones), 32'd0);
            check($sformatf("hold%0d.az", i), 32'(all_zero), 32'd0);
        end

        // Asynchronous reset while a result is showing.
        apply_stimulus(1'b1, 15'h7FFF);
        check("prerst.valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.valid", 32'(out_valid), 32'd0);
        check("arst.lo", 32'(leading_ones), 32'd0);
        check("arst.ao", 32'(all_one), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            apply_stimulus(1'b0, 15'h1234);
            check("idle.valid", 32'(out_valid), 32'd0);
            check("idle.lz", 32'(leading_zeroes), 32'd0);
        end

        // Exhaustive sweep with the mutual-exclusion property on every result.
        for (int n = 0; n < 32768; n++) begin
            apply_stimulus(1'b1, 15'(n));
            check_result("sweep", 15'(n));
            check("sweep.excl", 32'((leading_zeroes == 4'd0) != (leading_ones == 4'd0)), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/leading_count15.md
Name: leading_count15

Overview:
- Registered leading-zero / leading-one counter for a 15-bit field.
- Used by the posit decode path: the magnitude bits of a 16-bit posit (sign bit excluded) are counted to find the regime run length.
- Both counts come out together, one cycle after input.
- Same function as clz15 / clo15, merged into one pipelined block.

Parameters:
- WIDTH, 15, width of the counted field; bit WIDTH-1 is the MSB, counting starts there.
- CNT_W, 4, count width = clog2(WIDTH+1); must hold the value WIDTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  num is sampled on this cycle.
- num  input  WIDTH  field to be counted.
- out_valid  output  1  counts are valid this cycle.
- leading_zeroes  output  CNT_W  number of consecutive 0 bits from num[WIDTH-1] downward.
- leading_ones  output  CNT_W  number of consecutive 1 bits from num[WIDTH-1] downward.
- all_zero  output  1  registered num == 0.
- all_one  output  1  registered num == all ones.

Behaviour:
- Reset (rst_n low, asynchronous assert): out_valid=0, leading_zeroes=0, leading_ones=0, all_zero=0, all_one=0.
- Reset deassertion is synchronised by the system; no output changes until the next in_valid.
- Latency: exactly 1 cycle.
  - If in_valid=1 at edge N, outputs at edge N reflect that num and out_valid=1.
  - If in_valid=0 at edge N, out_valid=0 and the count/flag registers hold their previous values.
- No backpressure; a new input is accepted every cycle (throughput 1/cycle).
- Counting rule:
  - leading_zeroes = index distance from MSB to the first 1 bit.
  - leading_ones = index distance from MSB to the first 0 bit.
- Mutual exclusion:
  - If num[WIDTH-1]=0 then leading_ones=0 and leading_zeroes>=1.
  - If num[WIDTH-1]=1 then leading_zeroes=0 and leading_ones>=1.
  - Exactly one count is nonzero for every input.
- Saturation bounds:
  - num=0 gives leading_zeroes=15 (=WIDTH) and all_zero=1.
  - num=all ones gives leading_ones=15 and all_one=1.
  - Counts never exceed WIDTH; no wrap in CNT_W bits.
- Counting logic is purely combinational ahead of the output register (priority encoder or log-depth tree); it must close timing in one cycle.
- Reset asserted mid-stream: in-flight result is discarded and outputs go to reset values immediately (asynchronous).
- X on num while in_valid=0 must not propagate to the outputs.

Decomposition:
- Shared package posit_pkg holds:
  - constants POSIT_NBITS=16 and POSIT_ES=1;
  - derived constants LC_WIDTH = POSIT_NBITS-1 and LC_CNT_W = clog2(POSIT_NBITS).
- One combinational sub-module, leading_count_core (WIDTH, CNT_W params): counts leading zeros of its input.
  - Instantiated twice: once on num, once on ~num to obtain the leading-ones count.
- The top level adds only the valid/output registers and the all_zero/all_one flags.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with out_valid=1 → all outputs 0 immediately. Release and idle → out_valid stays 0.
- Extremes:
  - num=15'h0000 → next cycle out_valid=1, leading_zeroes=15, leading_ones=0, all_zero=1.
  - num=15'h7FFF → leading_ones=15, leading_zeroes=0, all_one=1.
- Walking sequence, back-to-back with in_valid=1 (num = 1, 5, 33, 229, 1601, 11205):
  - 1 → lz=14
  - 5 → lz=12
  - 33 → lz=9
  - 229 → lz=7
  - 1601 → lz=4
  - 11205 (15'b010101111000101) → lz=1
  - all with lo=0, one result per cycle, correct ordering.
- Leading ones:
  - num=15'h6000 → lo=2, lz=0
  - num=15'h4000 → lo=1, lz=0
  - num=15'h7FFE → lo=14, lz=0
- Hold: present num=15'h0010 (lz=10), then in_valid=0 with num=X for 3 cycles → out_valid=0, leading_zeroes holds 10, no X on outputs.
- Exhaustive: all 32768 values compared against a reference model (lz = 14 - floor(log2 num) for num>0, lo computed on ~num). Check the mutual-exclusion property every cycle.
